// File: rtl/gabor_pkg.sv
// Shared defaults and state encoding for the Gabor output
// write-back controller.
package gabor_pkg;

    localparam int N_REQ_DEF     = 2;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 8;
    localparam int FRAME_LEN_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE,
        HOLD
    } wb_state_t;

endpackage

// File: rtl/gabor_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant among requesters,
// search starts at the lane after the last advanced grant.
module gabor_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        nxt   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= nxt;
        end
    end

endmodule

// File: rtl/gabor_out_wb_ctrl.sv
// Write-back scheduler for the Gabor output RAM: arbitrates
// filter lanes into sequential frame writes, then serves reads.
module gabor_out_wb_ctrl
    import gabor_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    wb_state_t         state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic              rd_s1;
    logic [DATA_W-1:0] gnt_word;

    gabor_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready  = (state == FILL) ? grant : '0;
    assign accept     = |req_ready;
    assign busy       = (state == FILL);
    assign frame_done = (state == DONE);
    assign rd_data    = ram_rdata;

    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_word = gnt_word | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // An accepted word is written even in a cycle that aborts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_s1     <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            rd_s1    <= 1'b0;
            rd_valid <= rd_s1;
            if (accept) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_cnt;
                ram_wdata <= gnt_word;
            end
            unique case (state)
                IDLE, HOLD: begin
                    if (frame_start) begin
                        state  <= FILL;
                        wr_cnt <= '0;
                    end else if (rd_req) begin
                        ram_addr <= rd_addr;
                        rd_s1    <= 1'b1;
                    end
                end
                FILL: begin
                    if (frame_start) begin
                        wr_cnt <= '0;
                    end else if (accept) begin
                        if (wr_cnt == LAST) begin
                            wr_cnt <= '0;
                            state  <= DONE;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gabor_out_wb_ctrl.sv
// Randomized self-checking bench for gabor_out_wb_ctrl with a
// behavioural RAM and a round-robin write-order reference model.
module tb_gabor_out_wb_ctrl;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int FL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_start;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            frame_done;

    logic            bd_we;
    logic [AW-1:0]   bd_addr;
    logic [DW-1:0]   bd_data;
    logic [DW-1:0]   mem [0:255];

    int checks;
    int errors;
    int done_cnt;
    int rv_cnt;
    int mdl_ptr;
    int mdl_cnt;

    logic [AW+DW-1:0] obs_wr [$];
    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    lane_q [N][$];
    logic [N-1:0]     held;

    gabor_out_wb_ctrl #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .FRAME_LEN (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) obs_wr.push_back({ram_addr, ram_wdata});
        if (frame_done) done_cnt++;
        if (rd_valid) rv_cnt++;
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;
        held        = '0;
        mdl_ptr     = 0;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // Lanes present words; grants checked against round-robin rule.
    task automatic drive_frame(input int n_acc, input bit rnd,
                               output int cycles);
        int g;
        logic [N-1:0] exp_g;
        cycles  = 0;
        mdl_cnt = 0;
        exp_wr.delete();
        while (mdl_cnt < n_acc && cycles < 60) begin
            for (int i = 0; i < N; i++) begin
                if (!held[i] && lane_q[i].size() > 0 &&
                    (!rnd || $urandom_range(0, 1) == 1))
                    held[i] = 1'b1;
            end
            req_valid = held;
            for (int i = 0; i < N; i++)
                req_data[i*DW +: DW] = held[i] ? lane_q[i][0] : '0;
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && held[(mdl_ptr + k) % N])
                    g = (mdl_ptr + k) % N;
            end
            exp_g = '0;
            if (g >= 0) exp_g[g] = 1'b1;
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL grant got %b want %b", req_ready, exp_g);
            end
            if (g >= 0) begin
                exp_wr.push_back({AW'(mdl_cnt), lane_q[g][0]});
                void'(lane_q[g].pop_front());
                held[g] = 1'b0;
                mdl_ptr = (g + 1) % N;
                mdl_cnt++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        req_valid = held;
        checks++;
        if (mdl_cnt != n_acc) begin
            errors++;
            $display("FAIL fill_timeout got %0d want %0d", mdl_cnt, n_acc);
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        #1;
        checks++;
        if ({req_ready, ram_we, ram_addr, ram_wdata, rd_valid, busy,
             frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %h %h %b %b %b",
                     req_ready, ram_we, ram_addr, ram_wdata, rd_valid,
                     busy, frame_done);
        end
        req_valid = '0;
    endtask

    task automatic test_idle_read();
        logic [DW-1:0] v;
        v       = $urandom();
        bd_we   = 1'b1;
        bd_addr = 8'd5;
        bd_data = v;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 8'd5;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || ram_addr !== 8'd5 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_addr got v%b a%h we%b want v0 a05 we0",
                     rd_valid, ram_addr, ram_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== v) begin
            errors++;
            $display("FAIL idle_read_data got %b %h want 1 %h",
                     rd_valid, rd_data, v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_once got %b want 0", rd_valid);
        end
    endtask

    task automatic test_both_lanes();
        int base, d0, cyc;
        do_reset();
        start_frame();
        for (int i = 0; i < 2; i++) begin
            lane_q[0].push_back($urandom());
            lane_q[1].push_back($urandom());
        end
        base = obs_wr.size();
        d0   = done_cnt;
        drive_frame(FL, 1'b0, cyc);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_done got fd%b busy%b want fd1 busy0",
                     frame_done, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL both_pulse got fd%b cnt%0d want fd0 cnt1",
                     frame_done, done_cnt - d0);
        end
        checks++;
        if (obs_wr.size() - base != FL) begin
            errors++;
            $display("FAIL both_nwr got %0d want %0d",
                     obs_wr.size() - base, FL);
        end
        for (int k = 0; k < FL && base + k < obs_wr.size(); k++) begin
            checks++;
            if (obs_wr[base+k] !== exp_wr[k]) begin
                errors++;
                $display("FAIL both_wr%0d got %h want %h",
                         k, obs_wr[base+k], exp_wr[k]);
            end
        end
    endtask

    task automatic test_lane1_only();
        int base, cyc;
        do_reset();
        start_frame();
        for (int i = 0; i < FL; i++) lane_q[1].push_back($urandom());
        base = obs_wr.size();
        drive_frame(FL, 1'b0, cyc);
        @(posedge clk);
        #1;
        checks++;
        if (cyc != FL || obs_wr.size() - base != FL) begin
            errors++;
            $display("FAIL lane1_gaps got cyc%0d wr%0d want %0d",
                     cyc, obs_wr.size() - base, FL);
        end
        for (int k = 0; k < FL && base + k < obs_wr.size(); k++) begin
            checks++;
            if (obs_wr[base+k] !== exp_wr[k]) begin
                errors++;
                $display("FAIL lane1_wr%0d got %h want %h",
                         k, obs_wr[base+k], exp_wr[k]);
            end
        end
    endtask

    task automatic test_abort();
        int base, d0, cyc;
        do_reset();
        start_frame();
        lane_q[0].push_back($urandom());
        lane_q[1].push_back($urandom());
        base = obs_wr.size();
        d0   = done_cnt;
        drive_frame(2, 1'b0, cyc);
        start_frame();
        checks++;
        if (busy !== 1'b1 || done_cnt != d0 ||
            obs_wr.size() - base != 2) begin
            errors++;
            $display("FAIL abort_state got busy%b done%0d wr%0d want 1 0 2",
                     busy, done_cnt - d0, obs_wr.size() - base);
        end
        for (int k = 0; k < 2 && base + k < obs_wr.size(); k++) begin
            checks++;
            if (obs_wr[base+k] !== exp_wr[k]) begin
                errors++;
                $display("FAIL abort_pre%0d got %h want %h",
                         k, obs_wr[base+k], exp_wr[k]);
            end
        end
        base = obs_wr.size();
        for (int i = 0; i < 2; i++) begin
            lane_q[0].push_back($urandom());
            lane_q[1].push_back($urandom());
        end
        drive_frame(FL, 1'b1, cyc);
        checks++;
        if (frame_done !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_done got fd%b early%0d want fd1 early0",
                     frame_done, done_cnt - d0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < FL && base + k < obs_wr.size(); k++) begin
            checks++;
            if (obs_wr[base+k] !== exp_wr[k]) begin
                errors++;
                $display("FAIL abort_wr%0d got %h want %h",
                         k, obs_wr[base+k], exp_wr[k]);
            end
        end
    endtask

    task automatic test_read_in_fill();
        int base, r0, cyc;
        do_reset();
        start_frame();
        for (int i = 0; i < 2; i++) begin
            lane_q[0].push_back($urandom());
            lane_q[1].push_back($urandom());
        end
        base    = obs_wr.size();
        r0      = rv_cnt;
        rd_req  = 1'b1;
        rd_addr = AW'($urandom_range(0, 255));
        drive_frame(FL, 1'b1, cyc);
        rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rv_cnt != r0) begin
            errors++;
            $display("FAIL fill_read got %0d rd_valid want 0", rv_cnt - r0);
        end
        for (int k = 0; k < FL && base + k < obs_wr.size(); k++) begin
            checks++;
            if (obs_wr[base+k] !== exp_wr[k]) begin
                errors++;
                $display("FAIL fill_read_wr%0d got %h want %h",
                         k, obs_wr[base+k], exp_wr[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, d0, cyc;
        do_reset();
        start_frame();
        for (int i = 0; i < FL; i++) lane_q[0].push_back($urandom());
        drive_frame(2, 1'b0, cyc);
        req_valid = 2'b01;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, ram_we, ram_addr, ram_wdata, busy,
             frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_mid got %b %b %h %h %b %b", req_ready,
                     ram_we, ram_addr, ram_wdata, busy, frame_done);
        end
        req_valid = '0;
        held      = '0;
        mdl_ptr   = 0;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        base  = obs_wr.size();
        d0    = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || obs_wr.size() != base || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got done%0d wr%0d busy%b want 0 0 0",
                     done_cnt - d0, obs_wr.size() - base, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [DW-1:0] w;
        do_reset();
        start_frame();
        for (int i = 0; i < 3; i++) begin
            lane_q[0].push_back($urandom());
            lane_q[1].push_back($urandom());
        end
        drive_frame(FL, 1'b1, cyc);
        @(posedge clk);
        #1;
        held      = '0;
        req_valid = '0;
        for (int k = 1; k <= FL + 2; k++) begin
            rd_req  = (k - 1 < FL);
            rd_addr = AW'(k - 1);
            @(posedge clk);
            #1;
            if (k >= 2 && k <= FL + 1) begin
                w = exp_wr[k-2][DW-1:0];
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== w) begin
                    errors++;
                    $display("FAIL readback%0d got %b %h want 1 %h",
                             k - 2, rd_valid, rd_data, w);
                end
            end
        end
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL readback_end got %b want 0", rd_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();
        test_reset();
        test_idle_read();
        test_both_lanes();
        test_lane1_only();
        test_abort();
        test_read_in_fill();
        test_reset_mid();
        for (int r = 0; r < 3; r++) test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
